pending_encoder_32to5: RTL and testbench
========================================

// Module: pending_encoder_32to5
// PURPOSE
//  Inverse companion of the 5-to-32 decoder: collects multi-hot 32-bit request pulses into a pending set.
//  Encodes the set one index at a time into a 5-bit code with a valid/ready handshake.
//  Used where many one-hot sources (register-write events, exception causes) must be serialised into a 5-bit id.
// PARAMETERS
//  N      32  number of request lines (fixed at 32 for this revision)
//  IDX_W  5   index width, $clog2(N)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst_n      in   1   synchronous, active-low reset
//  req_i      in   32  request pulses; bit k high for one cycle sets pending[k]
//  ready_i    in   1   consumer accepts idx_o this cycle
//  valid_o    out  1   idx_o/onehot_o hold a granted index
//  idx_o      out  5   granted index (binary)
//  onehot_o   out  32  1<<idx_o when valid_o, else 0 (registered, not decoded from idx_o)
//  pending_o  out  32  current pending set (excludes the bit held in the output slot)
//  count_o    out  6   popcount(pending_o), range 0..32
// BEHAVIOUR
//  Reset (rst_n low at edge): pending=0, valid_o=0, idx_o=0, onehot_o=0, count_o=0, rr_last=31; held grant dropped
//  fire = valid_o & ready_i; slot loads when (!valid_o | fire) and pending!=0
//  Load: winner w from pending; idx_o<=w, onehot_o<=1<<w, valid_o<=1; pending[w] cleared same edge
//  Slot empty after fire with pending==0: valid_o<=0, idx_o holds last value, onehot_o<=0
//  FSM: IDLE (valid_o=0) -> GRANT on pending!=0; GRANT stays while !ready_i (outputs stable);
//   GRANT -> GRANT on fire with pending!=0 (back-to-back, 1 index/cycle); GRANT -> IDLE on fire with pending==0
//  Latency: req_i at cycle t -> pending at t+1 -> valid_o at t+2 (slot empty)
//  pending_next = (pending & ~load_mask) | req_i; set wins over clear for the same bit
//  req_i for the bit in the output slot re-sets pending (counted as a new event, served again)
//  Repeated req_i on an already-pending bit coalesces (no count increase)
//  ready_i while valid_o=0 is ignored; valid_o never drops without fire or reset
//  count_o registered, consistent with pending_o the same cycle
// CONFIGURATION
//  ROUND_ROBIN_EN defined: search starts at (rr_last+1) mod 32, wraps 31->0; rr_last<=w on each load
//  ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; rr_last absent
// STRUCTURE
//  Package mips_enc_pkg: N_LINES=32, IDX_W=5, CNT_W=6, function onehot5(idx) -> 32-bit
//  Sub-module priority_pick_32: combinational find-first-set over 32 bits from start index;
//   outputs found, idx[4:0]; start tied to 0 when ROUND_ROBIN_EN undefined
//  Top holds pending reg, output slot, rr_last, popcount
// TESTING
//  Reset: drive req_i=32'hFFFF_FFFF with rst_n=0 -> valid_o=0, pending_o=0, count_o=0 after edge
//  req_i=32'h0001_0005 one cycle, ready_i=1 -> idx_o 0,2,16 on consecutive cycles, then valid_o=0
//  ready_i=0, req_i=32'h8000_0001 -> idx_o=0 held stable, pending_o=32'h8000_0000, count_o=1 for many cycles
//  Slot holds idx 3, req_i=32'h8 same cycle as fire -> idx 3 granted again next load (set wins)
//  ROUND_ROBIN_EN: after grant 31, pending=32'h8000_0002 -> next grant 1 (wrap), then 31
//  rst_n=0 while valid_o=1, count_o=4 -> next cycle valid_o=0, onehot_o=0, count_o=0

Source files
------------

// File: rtl/mips_enc_pkg.sv
// Shared sizes, output-slot payload and helpers for the pending encoder.
//   N_LINES  number of request lines
//   IDX_W    index width
//   CNT_W    pending-count width (must hold 0..N_LINES)
package mips_enc_pkg;

  localparam int unsigned N_LINES = 32;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 6;

  // Contents of the output slot presented to the consumer.
  typedef struct packed {
    logic               valid;
    logic [IDX_W-1:0]   idx;
    logic [N_LINES-1:0] onehot;
  } slot_t;

  // 5-bit index to 32-bit one-hot.
  function automatic logic [N_LINES-1:0] onehot5(input logic [IDX_W-1:0] idx);
    return N_LINES'(1) << idx;
  endfunction

  // Number of set bits in a request-line vector.
  function automatic logic [CNT_W-1:0] popcount32(input logic [N_LINES-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/priority_pick_32.sv
// Combinational find-first-set over 32 bits, searching upward from a start
// index and wrapping 31 -> 0.
//   vec    in   32  candidate bits
//   start  in   5   first position examined
//   found  out  1   at least one bit of vec is set
//   idx    out  5   first set position at or after start (0 when !found)
module priority_pick_32
  import mips_enc_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // The 5-bit sum wraps naturally, giving the modulo-32 search order.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_LINES; k++) begin
      if (!found && vec[start + IDX_W'(k)]) begin
        found = 1'b1;
        idx   = start + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/pending_encoder_32to5.sv
// Collects multi-hot request pulses into a pending set and serialises the set
// one index per accepted transfer through a valid/ready output slot.
//   clk        in   1   clock
//   rst_n      in   1   synchronous active-low reset
//   req_i      in   32  request pulses, bit k sets pending[k]
//   ready_i    in   1   consumer accepts the slot this cycle
//   valid_o    out  1   slot holds a granted index
//   idx_o      out  5   granted index
//   onehot_o   out  32  one-hot of idx_o while valid_o, else 0
//   pending_o  out  32  pending set, excluding the slot's bit
//   count_o    out  6   popcount(pending_o)
// Build option: define ROUND_ROBIN_EN for a round-robin search starting after
// the last granted index; otherwise lowest index wins.
module pending_encoder_32to5
  import mips_enc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [N_LINES-1:0] onehot_o,
  output logic [N_LINES-1:0] pending_o,
  output logic [CNT_W-1:0]   count_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [N_LINES-1:0] pending;
  logic [N_LINES-1:0] pending_next;
  logic [N_LINES-1:0] load_mask;
  logic [CNT_W-1:0]   count_next;
  slot_t              slot_next;
  logic               fire;
  logic               load;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   pick_start;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_last;

  // Search begins just after the previous winner.
  assign pick_start = rr_last + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= IDX_W'(N_LINES - 1);
    end else if (load) begin
      rr_last <= pick_idx;
    end
  end
`else
  assign pick_start = '0;
`endif

  priority_pick_32 u_pick (
    .vec   (pending),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state, slot and pending-set computation.
  always_comb begin
    state_next       = state;
    slot_next.valid  = valid_o;
    slot_next.idx    = idx_o;
    slot_next.onehot = onehot_o;
    load_mask        = '0;
    load             = 1'b0;
    fire             = valid_o & ready_i;

    case (state)
      ST_IDLE: begin
        if (pick_found) load = 1'b1;
      end
      ST_GRANT: begin
        if (fire) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            // Slot drains; idx_o keeps its last value.
            state_next       = ST_IDLE;
            slot_next.valid  = 1'b0;
            slot_next.onehot = '0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (load) begin
      state_next       = ST_GRANT;
      slot_next.valid  = 1'b1;
      slot_next.idx    = pick_idx;
      slot_next.onehot = onehot5(pick_idx);
      load_mask        = onehot5(pick_idx);
    end

    // A new request for the bit being loaded re-arms it (set wins).
    pending_next = (pending & ~load_mask) | req_i;
    count_next   = popcount32(pending_next);
  end

  // State, slot and pending registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pending  <= '0;
      count_o  <= '0;
      valid_o  <= 1'b0;
      idx_o    <= '0;
      onehot_o <= '0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      count_o  <= count_next;
      valid_o  <= slot_next.valid;
      idx_o    <= slot_next.idx;
      onehot_o <= slot_next.onehot;
    end
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// Self-checking bench for pending_encoder_32to5: directed scenarios plus
// randomized traffic against a cycle-level reference model.
// Honours ROUND_ROBIN_EN the same way as the design.
module tb_pending_encoder_32to5;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_i;
  logic        ready_i;
  logic        valid_o;
  logic [4:0]  idx_o;
  logic [31:0] onehot_o;
  logic [31:0] pending_o;
  logic [5:0]  count_o;

  int n_checks;
  int n_fail;

  // Reference model state.
  bit [31:0] m_pend;
  bit        m_valid;
  int        m_idx;
`ifdef ROUND_ROBIN_EN
  int        m_rr;
`endif

  pending_encoder_32to5 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .idx_o     (idx_o),
    .onehot_o  (onehot_o),
    .pending_o (pending_o),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Winner selection straight from the rules: scan positions in search order.
  function automatic int model_pick(input bit [31:0] p);
    int first;
`ifdef ROUND_ROBIN_EN
    first = (m_rr + 1) % 32;
`else
    first = 0;
`endif
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (first + k) % 32;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_update(input bit [31:0] req, input bit rdy, input bit rst);
    bit fire;
    int w;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
`ifdef ROUND_ROBIN_EN
      m_rr    = 31;
`endif
    end else begin
      fire = m_valid && rdy;
      w    = model_pick(m_pend);
      if ((!m_valid || fire) && w >= 0) begin
        m_pend[w] = 1'b0;
        m_valid   = 1'b1;
        m_idx     = w;
`ifdef ROUND_ROBIN_EN
        m_rr      = w;
`endif
      end else if (fire) begin
        m_valid = 1'b0;
      end
      m_pend = m_pend | req;
    end
  endtask

  task automatic compare_model();
    bit [31:0] exp_oh;
    exp_oh = m_valid ? (32'd1 << m_idx) : 32'd0;
    check_eq("valid_o",   32'(valid_o),   32'(m_valid));
    check_eq("idx_o",     32'(idx_o),     32'(m_idx));
    check_eq("onehot_o",  onehot_o,       exp_oh);
    check_eq("pending_o", pending_o,      m_pend);
    check_eq("count_o",   32'(count_o),   32'($countones(m_pend)));
  endtask

  // One clock: drive inputs, take the edge, advance model, sample #1 later.
  task automatic step(input logic [31:0] req, input logic rdy, input logic rst);
    rst_n   = ~rst;
    req_i   = req;
    ready_i = rdy;
    @(posedge clk);
    model_update(req, rdy, rst);
    #1;
    compare_model();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req_i    = '0;
    ready_i  = 1'b0;

    // Reset dominates all-ones requests.
    step(32'hFFFF_FFFF, 1'b1, 1'b1);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_pend",  pending_o,    32'd0);
    check_eq("rst_count", 32'(count_o), 32'd0);
    check_eq("rst_idx",   32'(idx_o),   32'd0);

    // Three requests drain back-to-back in order 0, 2, 16.
    step(32'h0001_0005, 1'b1, 1'b0);
    check_eq("seq_pend", pending_o, 32'h0001_0005);
    check_eq("seq_valid0", 32'(valid_o), 32'd0);
    step(32'h0, 1'b1, 1'b0);
    check_eq("seq_idx0", 32'(idx_o), 32'd0);
    step(32'h0, 1'b1, 1'b0);
    check_eq("seq_idx2", 32'(idx_o), 32'd2);
    step(32'h0, 1'b1, 1'b0);
    check_eq("seq_idx16", 32'(idx_o), 32'd16);
    check_eq("seq_oh16", onehot_o, 32'h0001_0000);
    step(32'h0, 1'b1, 1'b0);
    check_eq("seq_drain", 32'(valid_o), 32'd0);
    check_eq("seq_hold_idx", 32'(idx_o), 32'd16);

    // Stall: slot and pending set stay put while ready is low.
    step(32'h0, 1'b0, 1'b1);
    step(32'h8000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(32'h0, 1'b0, 1'b0);
      check_eq("stall_idx",   32'(idx_o),   32'd0);
      check_eq("stall_valid", 32'(valid_o), 32'd1);
      check_eq("stall_pend",  pending_o,    32'h8000_0000);
      check_eq("stall_count", 32'(count_o), 32'd1);
    end

    // Re-request of the slot's own bit on the firing cycle is served again.
    step(32'h0, 1'b0, 1'b1);
    step(32'h8, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    check_eq("rearm_slot", 32'(idx_o), 32'd3);
    step(32'h8, 1'b1, 1'b0);
    check_eq("rearm_pend", pending_o, 32'h8);
    step(32'h0, 1'b1, 1'b0);
    check_eq("rearm_valid", 32'(valid_o), 32'd1);
    check_eq("rearm_idx",   32'(idx_o),   32'd3);

    // After granting 31, bits 31 and 1 pending: 1 comes first, then 31.
    step(32'h0, 1'b0, 1'b1);
    step(32'h8000_0000, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    check_eq("wrap_slot31", 32'(idx_o), 32'd31);
    step(32'h8000_0002, 1'b1, 1'b0);
    step(32'h0, 1'b1, 1'b0);
    check_eq("wrap_idx1", 32'(idx_o), 32'd1);
    step(32'h0, 1'b1, 1'b0);
    check_eq("wrap_idx31", 32'(idx_o), 32'd31);

    // Reset while a grant is held with four more pending.
    step(32'h0, 1'b0, 1'b1);
    step(32'h0000_001F, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    check_eq("mrst_pre_count", 32'(count_o), 32'd4);
    check_eq("mrst_pre_valid", 32'(valid_o), 32'd1);
    step(32'h0, 1'b0, 1'b1);
    check_eq("mrst_valid",  32'(valid_o), 32'd0);
    check_eq("mrst_onehot", onehot_o,     32'd0);
    check_eq("mrst_count",  32'(count_o), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      logic        rdy;
      logic        rst;
      case ($urandom_range(0, 3))
        0: r = 32'h0;
        1: r = 32'd1 << $urandom_range(0, 31);
        2: r = $urandom & $urandom & $urandom;
        default: r = $urandom;
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step(r, rdy, rst);
    end

    // Let the set drain completely.
    for (int i = 0; i < 40; i++) step(32'h0, 1'b1, 1'b0);
    check_eq("final_valid", 32'(valid_o), 32'd0);
    check_eq("final_pend",  pending_o,    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
